// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the AXI read-channel arbiter.
//   arb_state_e  : arbiter FSM states (idle / address phase / data phase)
//   ARB_ID_WIDTH : width of the AXI ARID/RID fields
//   ARB_LEN_WIDTH: width of the AXI ARLEN field (burst length - 1)
//   idxWidth()   : width needed to hold a master index, never less than 1
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    localparam int ARB_ID_WIDTH  = 4;
    localparam int ARB_LEN_WIDTH = 4;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin selector. Scans the request vector starting
// one position above the previous grant and wrapping around, so the master
// that was served last has the lowest priority.
// Ports:
//   req     in  N      request vector
//   last    in  IDX_W  index of the previously granted master
//   gnt_idx out IDX_W  index of the selected master (0 when nothing requests)
//   gnt_any out 1      at least one request is pending
// -----------------------------------------------------------------------------
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = idxWidth(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    // Walk offsets 1..N from the last grant; the first pending request wins.
    // Offset N lands back on the last winner, so a lone requester is still served.
    always_comb begin
        int   pos;
        logic found;
        gnt_idx = '0;
        gnt_any = |req;
        found   = 1'b0;
        pos     = 0;
        for (int k = 1; k <= N; k++) begin
            pos = int'(last) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && req[pos]) begin
                gnt_idx = IDX_W'(pos);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// -----------------------------------------------------------------------------
// mem_read_arbiter
// Shares one AXI read channel between N_MASTERS read masters (i_cache, d_cache,
// stream buffer). Round-robin grant, a single burst outstanding at a time, and
// R beats routed back to the winner by RID.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   m_arvalid/m_araddr/m_arlen per-master read request, address, length-1
//   m_arready                  one-hot accept pulse to the granted master
//   m_rvalid/m_rlast           one-hot beat valid / last marker to the winner
//   m_rdata                    shared read data (RDATA pass-through)
//   ARVALID/ARREADY/ARID/ARLEN/ARADDR   AXI read address channel
//   RVALID/RLAST/RID/RDATA/RREADY       AXI read data channel
//   busy                       arbiter is not idle
//   rid_err                    sticky flag: a beat with a foreign RID was seen
// -----------------------------------------------------------------------------
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_MASTERS  = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = idxWidth(N_MASTERS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_MASTERS-1:0]              m_arvalid,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]   m_araddr,
    input  logic [N_MASTERS*ARB_LEN_WIDTH-1:0] m_arlen,
    output logic [N_MASTERS-1:0]              m_arready,
    output logic [N_MASTERS-1:0]              m_rvalid,
    output logic [N_MASTERS-1:0]              m_rlast,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic                              ARVALID,
    input  logic                              ARREADY,
    output logic [ARB_ID_WIDTH-1:0]           ARID,
    output logic [ARB_LEN_WIDTH-1:0]          ARLEN,
    output logic [ADDR_WIDTH-1:0]             ARADDR,
    input  logic                              RVALID,
    input  logic                              RLAST,
    input  logic [ARB_ID_WIDTH-1:0]           RID,
    input  logic [DATA_WIDTH-1:0]             RDATA,
    output logic                              RREADY,
    output logic                              busy,
    output logic                              rid_err
);

    arb_state_e                 state_q, state_d;
    logic [IDX_W-1:0]           winner_q, winner_d;
    logic [IDX_W-1:0]           last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [ARB_LEN_WIDTH-1:0]   len_q, len_d;
    logic                       rid_err_q, rid_err_d;

    logic [IDX_W-1:0]           pick_idx;
    logic                       pick_any;
    logic [ADDR_WIDTH-1:0]      sel_addr;
    logic [ARB_LEN_WIDTH-1:0]   sel_len;
    logic [N_MASTERS-1:0]       winner_oh;
    logic                       id_match;

    rr_picker #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (m_arvalid),
        .last    (last_grant_q),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // Mux out the picked master's address and length with a compare per slot,
    // so an index beyond N_MASTERS-1 can never select past the packed buses.
    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_addr = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = m_arlen[i*ARB_LEN_WIDTH +: ARB_LEN_WIDTH];
            end
        end
    end

    // One-hot of the latched winner; every per-master strobe is gated by it,
    // which guarantees a non-winner never sees a handshake.
    always_comb begin
        winner_oh = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            winner_oh[i] = (winner_q == IDX_W'(i));
        end
    end

    assign id_match = (RID == ARB_ID_WIDTH'(winner_q));

    // State and latch registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            winner_q     <= '0;
            last_grant_q <= IDX_W'(N_MASTERS - 1);
            addr_q       <= '0;
            len_q        <= '0;
            rid_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            rid_err_q    <= rid_err_d;
        end
    end

    // Next-state and handshake decode. The request is captured on the IDLE
    // cycle, so later changes on m_arvalid/m_araddr cannot disturb the burst.
    // Foreign-RID beats are still accepted (RREADY stays high) so the
    // interconnect never stalls on them; they are only flagged.
    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        rid_err_d    = rid_err_q;
        ARVALID      = 1'b0;
        RREADY       = 1'b0;
        m_arready    = '0;
        m_rvalid     = '0;
        m_rlast      = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    winner_d = pick_idx;
                    addr_d   = sel_addr;
                    len_d    = sel_len;
                    state_d  = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                ARVALID = 1'b1;
                if (ARREADY) begin
                    m_arready = winner_oh;
                    state_d   = ARB_DATA;
                end
            end
            ARB_DATA: begin
                RREADY = 1'b1;
                if (RVALID) begin
                    if (id_match) begin
                        m_rvalid = winner_oh;
                        if (RLAST) begin
                            m_rlast      = winner_oh;
                            last_grant_d = winner_q;
                            state_d      = ARB_IDLE;
                        end
                    end else begin
                        rid_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign ARID    = ARB_ID_WIDTH'(winner_q);
    assign ARLEN   = len_q;
    assign ARADDR  = addr_q;
    assign m_rdata = RDATA;
    assign busy    = (state_q != ARB_IDLE);
    assign rid_err = rid_err_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_read_arbiter
// Directed testbench for mem_read_arbiter (3 masters, 32-bit address/data).
// Inputs change #1 after the rising edge; outputs are sampled #2 after it.
// -----------------------------------------------------------------------------
module tb_mem_read_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      m_arvalid;
    logic [N*AW-1:0]   m_araddr;
    logic [N*4-1:0]    m_arlen;
    logic [N-1:0]      m_arready;
    logic [N-1:0]      m_rvalid;
    logic [N-1:0]      m_rlast;
    logic [DW-1:0]     m_rdata;
    logic              ARVALID;
    logic              ARREADY;
    logic [3:0]        ARID;
    logic [3:0]        ARLEN;
    logic [AW-1:0]     ARADDR;
    logic              RVALID;
    logic              RLAST;
    logic [3:0]        RID;
    logic [DW-1:0]     RDATA;
    logic              RREADY;
    logic              busy;
    logic              rid_err;

    int testsRun  = 0;
    int testsFail = 0;

    mem_read_arbiter #(
        .N_MASTERS  (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_arvalid (m_arvalid),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arready (m_arready),
        .m_rvalid  (m_rvalid),
        .m_rlast   (m_rlast),
        .m_rdata   (m_rdata),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .ARID      (ARID),
        .ARLEN     (ARLEN),
        .ARADDR    (ARADDR),
        .RVALID    (RVALID),
        .RLAST     (RLAST),
        .RID       (RID),
        .RDATA     (RDATA),
        .RREADY    (RREADY),
        .busy      (busy),
        .rid_err   (rid_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something upstream wedges the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: observed=0x%0h required=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setMaster(input int m, input logic [AW-1:0] addr, input logic [3:0] len);
        m_araddr[m*AW +: AW] = addr;
        m_arlen[m*4 +: 4]    = len;
    endtask

    task automatic applyStimulus();
        m_arvalid = '0;
        m_araddr  = '0;
        m_arlen   = '0;
        ARREADY   = 1'b0;
        RVALID    = 1'b0;
        RLAST     = 1'b0;
        RID       = '0;
        RDATA     = '0;
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    // Drives one full burst starting from an IDLE cycle in which the request is
    // already presented. Checks address phase, optional ARREADY stall, optional
    // stray beat with a foreign RID, every data beat, and the return to IDLE.
    task automatic runBurst(input int w, input logic [AW-1:0] addr, input logic [3:0] len,
                            input int stall, input bit drop, input bit stray);
        logic [N-1:0] oh;
        logic [DW-1:0] beatData;
        oh = 3'b001 << w;
        ARREADY = (stall == 0);
        tick();
        for (int s = 0; s < stall; s++) begin
            #1;
            checkOutput("stall_arvalid", ARVALID, 1);
            checkOutput("stall_araddr", ARADDR, addr);
            checkOutput("stall_arid", ARID, w);
            checkOutput("stall_arready", m_arready, 0);
            tick();
        end
        ARREADY = 1'b1;
        #1;
        checkOutput("addr_arvalid", ARVALID, 1);
        checkOutput("addr_arid", ARID, w);
        checkOutput("addr_araddr", ARADDR, addr);
        checkOutput("addr_arlen", ARLEN, len);
        checkOutput("addr_m_arready", m_arready, oh);
        checkOutput("addr_busy", busy, 1);
        if (drop) m_arvalid = '0;
        tick();
        #1;
        checkOutput("data_rready", RREADY, 1);
        checkOutput("data_arvalid", ARVALID, 0);
        checkOutput("data_m_arready", m_arready, 0);
        for (int b = 0; b <= int'(len); b++) begin
            if (stray && b == 1) begin
                RVALID = 1'b1;
                RID    = (w == 0) ? 4'd1 : 4'd0;
                RLAST  = 1'b1;
                RDATA  = 32'hDEAD_BEEF;
                #1;
                checkOutput("stray_m_rvalid", m_rvalid, 0);
                checkOutput("stray_m_rlast", m_rlast, 0);
                tick();
                #1;
                checkOutput("stray_rid_err", rid_err, 1);
                checkOutput("stray_busy", busy, 1);
            end
            beatData = 32'hA000_0000 | (w << 8) | b;
            RVALID = 1'b1;
            RID    = 4'(w);
            RLAST  = (b == int'(len));
            RDATA  = beatData;
            #1;
            checkOutput("beat_m_rvalid", m_rvalid, oh);
            checkOutput("beat_m_rlast", m_rlast, (b == int'(len)) ? oh : 3'b000);
            checkOutput("beat_m_rdata", m_rdata, beatData);
            tick();
        end
        RVALID = 1'b0;
        RLAST  = 1'b0;
        #1;
        checkOutput("end_busy", busy, 0);
        checkOutput("end_rready", RREADY, 0);
        checkOutput("end_arvalid", ARVALID, 0);
    endtask

    initial begin
        applyStimulus();
        rst_n = 1'b0;
        #12;
        // Reset state
        checkOutput("rst_arvalid", ARVALID, 0);
        checkOutput("rst_rready", RREADY, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_rid_err", rid_err, 0);
        checkOutput("rst_arid", ARID, 0);
        checkOutput("rst_arlen", ARLEN, 0);
        checkOutput("rst_araddr", ARADDR, 0);
        checkOutput("rst_m_arready", m_arready, 0);
        rst_n = 1'b1;
        tick();

        // 1: single request from master 1, dropped during ADDR
        setMaster(1, 32'h0000_0100, 4'd3);
        m_arvalid = 3'b010;
        #1;
        checkOutput("t1_idle_arvalid", ARVALID, 0);
        runBurst(1, 32'h0000_0100, 4'd3, 0, 1'b1, 1'b0);

        // 2: all three requesting after reset -> 0,1,2,0,1,2
        pulseReset();
        setMaster(0, 32'h0000_1000, 4'd1);
        setMaster(1, 32'h0000_2000, 4'd0);
        setMaster(2, 32'h0000_3000, 4'd2);
        m_arvalid = 3'b111;
        for (int r = 0; r < 2; r++) begin
            runBurst(0, 32'h0000_1000, 4'd1, 0, 1'b0, 1'b0);
            runBurst(1, 32'h0000_2000, 4'd0, 0, 1'b0, 1'b0);
            runBurst(2, 32'h0000_3000, 4'd2, 0, 1'b0, 1'b0);
        end
        m_arvalid = '0;

        // 3: ARREADY held low for 5 cycles
        m_arvalid = 3'b001;
        runBurst(0, 32'h0000_1000, 4'd1, 5, 1'b1, 1'b0);

        // 4: foreign RID beat while master 2 owns the channel; flag is sticky
        setMaster(2, 32'h0000_3400, 4'd3);
        m_arvalid = 3'b100;
        runBurst(2, 32'h0000_3400, 4'd3, 0, 1'b1, 1'b1);
        checkOutput("t4_rid_err_sticky", rid_err, 1);

        // 5: single-beat bursts back to back from master 0
        setMaster(0, 32'h0000_0040, 4'd0);
        m_arvalid = 3'b001;
        for (int r = 0; r < 3; r++) begin
            runBurst(0, 32'h0000_0040, 4'd0, 0, 1'b0, 1'b0);
        end
        m_arvalid = '0;

        // 6: reset in the middle of a 4-beat burst from master 1
        setMaster(1, 32'h0000_2200, 4'd3);
        m_arvalid = 3'b010;
        ARREADY = 1'b1;
        tick();
        m_arvalid = '0;
        tick();
        for (int b = 0; b < 2; b++) begin
            RVALID = 1'b1;
            RID    = 4'd1;
            RLAST  = 1'b0;
            RDATA  = 32'h5500_0000 | b;
            tick();
        end
        #1;
        checkOutput("t6_beat2_m_rvalid", m_rvalid, 3'b010);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_rready", RREADY, 0);
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_m_rvalid", m_rvalid, 0);
        checkOutput("t6_rst_rid_err", rid_err, 0);
        checkOutput("t6_rst_araddr", ARADDR, 0);
        checkOutput("t6_rst_arlen", ARLEN, 0);
        checkOutput("t6_rst_arid", ARID, 0);
        rst_n = 1'b1;
        tick();
        #1;
        checkOutput("t6_post_rready", RREADY, 0);
        checkOutput("t6_post_m_rvalid", m_rvalid, 0);
        RVALID = 1'b0;
        setMaster(0, 32'h0000_0800, 4'd1);
        m_arvalid = 3'b111;
        runBurst(0, 32'h0000_0800, 4'd1, 0, 1'b0, 1'b0);
        m_arvalid = '0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
